mem_burst_ctrl: RTL and testbench
=================================

Name: mem_burst_ctrl

Overview:
- Sequences the synchronous single-port R/W memory array for one processor-side requester.
- Accepts one request (address, read/write) when idle, then runs a fixed-length wrapping burst of BURSTLEN beats, driving the memory's Addr/DataIn/rdEn/wrEn.
- Decodes a page field so that only requests to its own page are served.
- Sits between the processor bus model and the memory array.

Parameters:
- BUSWIDTH, 8: data width; matches the memory array.
- MEMSIZE, 256: memory depth in words. ADDRWIDTH = $clog2(MEMSIZE).
- BURSTLEN, 4: beats per burst; must be a power of 2 and ≤ MEMSIZE.
- PAGE, 8'h02: upper address field value this controller answers to.

Ports:
- clk  in  1  system clock; all state updates on its posedge.
- resetH  in  1  synchronous, active-high reset.
- req_valid  in  1  request strobe, sampled on posedge when req_ready=1.
- req_rw  in  1  1=read, 0=write.
- req_addr  in  8+ADDRWIDTH  {page[7:0], word address}.
- req_ready  out  1  controller idle and able to accept a request.
- wr_data  in  BUSWIDTH  write beat data; must be valid in every cycle wr_ready=1.
- wr_ready  out  1  current cycle is a write beat.
- rd_data  out  BUSWIDTH  registered read beat data.
- rd_valid  out  1  rd_data holds a valid beat this cycle.
- mem_addr  out  ADDRWIDTH  memory address.
- mem_din  out  BUSWIDTH  memory write data.
- mem_dout  in  BUSWIDTH  memory read data; combinational while mem_rdEn=1.
- mem_rdEn  out  1  memory read enable.
- mem_wrEn  out  1  memory write enable; the memory writes on posedge.

Behaviour:
- Reset state:
  - State goes to IDLE; beat counter=0.
  - req_ready=1; wr_ready, rd_valid, mem_rdEn, mem_wrEn=0.
  - rd_data, mem_addr, mem_din=0.
- States:
  - IDLE: accepts a request.
  - RD_BURST and WR_BURST: run the burst.
  - RD_DRAIN: one cycle to present the last registered read beat.
- IDLE transitions:
  - req_valid & page match & req_rw=1 → RD_BURST.
  - req_valid & page match & req_rw=0 → WR_BURST.
  - Latch start address S and clear beat counter b.
  - Page mismatch: request is dropped and state stays IDLE.
- Beat address:
  - mem_addr = {S[ADDRWIDTH-1:log2(BURSTLEN)], (S[log2 BURSTLEN-1:0] + b) mod BURSTLEN}.
  - Wrapping burst, e.g. S=0x07 with BURSTLEN=4 gives 07, 04, 05, 06.
  - The burst never crosses its aligned block.
- RD_BURST, for b = 0..BURSTLEN-1:
  - mem_rdEn=1.
  - On posedge: rd_data <= mem_dout and rd_valid <= 1.
  - After the last beat → RD_DRAIN.
  - Read latency: first beat on rd_data 2 cycles after the accept edge, then 1 beat per cycle.
- RD_DRAIN: mem_rdEn=0; rd_valid stays 1 for the final beat, then clears on the next edge → IDLE.
- WR_BURST, for b = 0..BURSTLEN-1:
  - mem_wrEn=1 and wr_ready=1.
  - mem_din = wr_data (combinational pass-through).
  - After the last beat → IDLE.
- mem_rdEn and mem_wrEn are never both 1.
- req_ready is 1 only in IDLE. A req_valid while busy is ignored; there is no queueing.
- A request arriving in the same cycle the controller returns to IDLE is accepted on the next edge (req_ready is already 1 in IDLE).
- Reset mid-burst: the burst aborts immediately.
  - Write beats already clocked stay in memory; remaining beats are not written.
  - No rd_valid is asserted after reset.
- Address arithmetic is unsigned, ADDRWIDTH bits; the beat counter is $clog2(BURSTLEN) bits wide.

Optional Feature:
- Macro: MEMCTRL_PAGE_ERR_EN.
- When defined:
  - Adds output req_err (1 bit, reset 0).
  - req_err pulses high for exactly 1 cycle after a req_valid in IDLE whose page ≠ PAGE.
  - Also adds an 8-bit saturating count err_cnt of such events; it holds at 255 and clears on reset.
- When undefined: these ports and the logic do not exist, and page mismatches are silently dropped.

Decomposition:
- Shared package mcDefs (existing) holds BUSWIDTH and MEMSIZE; add:
  - BURSTLEN.
  - PAGE_DEFAULT.
  - typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, RD_DRAIN} mc_state_t.
- One sub-module, burst_addr_gen: start-address latch, beat counter, wrap-address computation and last_beat flag.
- The FSM and the datapath stay in mem_burst_ctrl.

Test Plan:
- Reset test: hold resetH 2 cycles mid-write burst (after beat 1) → all outputs 0 next cycle, req_ready=1, and only beats 0–1 are present in memory.
- Write then read: write burst to {02,0x10} with data A0, A1, A2, A3; then read {02,0x10} → rd_valid for 4 consecutive cycles with A0..A3, first beat 2 cycles after the accept edge.
- Wrap test: write burst to 0x07 with data 11, 22, 33, 44 → memory locations 07=11, 04=22, 05=33, 06=44; locations 03 and 08 are untouched.
- Page filter: req_addr page=0x05 → no mem_rdEn/mem_wrEn activity and memory unchanged. With MEMCTRL_PAGE_ERR_EN defined, req_err pulses 1 cycle and err_cnt=1.
- Busy collision: issue a second req_valid during a read burst → it is ignored, and the first burst completes with 4 beats.
- Back-to-back: hold req_valid continuously (read, then write) → the second burst starts on the first edge where req_ready=1, and mem_rdEn and mem_wrEn are never both high.

Source files
------------

// File: rtl/mem_burst_ctrl_pkg.sv
// mcDefs: shared memory-controller constants and the burst FSM state type.
package mcDefs;
    localparam int BUSWIDTH = 8;
    localparam int MEMSIZE = 256;
    localparam int ADDRWIDTH = $clog2(MEMSIZE);
    localparam int BURSTLEN = 4;
    localparam logic [7:0] PAGE_DEFAULT = 8'h02;
    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, RD_DRAIN} mc_state_t;
endpackage

// File: rtl/mem_burst_ctrl_if.sv
// mem_burst_ctrl_if: requester and memory-array signals; req_err/err_cnt exist only with MEMCTRL_PAGE_ERR_EN.
interface mem_burst_ctrl_if #(
    parameter int BUSWIDTH = mcDefs::BUSWIDTH,
    parameter int ADDRWIDTH = mcDefs::ADDRWIDTH
);
    logic                   req_valid;
    logic                   req_rw;
    logic [ADDRWIDTH+7:0]   req_addr;
    logic                   req_ready;
    logic [BUSWIDTH-1:0]    wr_data;
    logic                   wr_ready;
    logic [BUSWIDTH-1:0]    rd_data;
    logic                   rd_valid;
    logic [ADDRWIDTH-1:0]   mem_addr;
    logic [BUSWIDTH-1:0]    mem_din;
    logic [BUSWIDTH-1:0]    mem_dout;
    logic                   mem_rdEn;
    logic                   mem_wrEn;
`ifdef MEMCTRL_PAGE_ERR_EN
    logic                   req_err;
    logic [7:0]             err_cnt;
`endif
    modport slave (
        input  req_valid, req_rw, req_addr, wr_data, mem_dout,
        output req_ready, wr_ready, rd_data, rd_valid, mem_addr, mem_din, mem_rdEn, mem_wrEn
`ifdef MEMCTRL_PAGE_ERR_EN
        , output req_err, err_cnt
`endif
    );
    modport master (
        output req_valid, req_rw, req_addr, wr_data, mem_dout,
        input  req_ready, wr_ready, rd_data, rd_valid, mem_addr, mem_din, mem_rdEn, mem_wrEn
`ifdef MEMCTRL_PAGE_ERR_EN
        , input req_err, err_cnt
`endif
    );
endinterface

// File: rtl/mem_burst_ctrl_burst_addr_gen.sv
// burst_addr_gen: latches the burst start address and produces wrapping beat addresses within the aligned block.
module burst_addr_gen #(
    parameter int ADDRWIDTH = mcDefs::ADDRWIDTH,
    parameter int BURSTLEN = mcDefs::BURSTLEN
) (
    input  logic                 clk,
    input  logic                 resetH,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic [ADDRWIDTH-1:0] i_start_addr,
    output logic [ADDRWIDTH-1:0] o_addr,
    output logic                 o_last
);
    localparam int CW = BURSTLEN > 1 ? $clog2(BURSTLEN) : 1;
    localparam logic [ADDRWIDTH-1:0] MASK = ADDRWIDTH'(BURSTLEN - 1);
    logic [ADDRWIDTH-1:0] r_start;
    logic [CW-1:0]        r_beat;
    always_ff @(posedge clk) begin
        if (resetH) begin
            r_start <= '0;
            r_beat  <= '0;
        end else if (i_load) begin
            r_start <= i_start_addr;
            r_beat  <= '0;
        end else if (i_step) begin
            r_beat  <= o_last ? '0 : r_beat + 1'b1;
        end
    end
    assign o_last = r_beat == CW'(BURSTLEN - 1);
    // Upper bits stay fixed, low bits count modulo BURSTLEN from the start offset
    assign o_addr = (r_start & ~MASK) | ((r_start + ADDRWIDTH'(r_beat)) & MASK);
endmodule

// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: page-filtered wrapping-burst sequencer for a single-port memory; MEMCTRL_PAGE_ERR_EN adds req_err/err_cnt.
module mem_burst_ctrl #(
    parameter int BUSWIDTH = mcDefs::BUSWIDTH,
    parameter int MEMSIZE = mcDefs::MEMSIZE,
    parameter int BURSTLEN = mcDefs::BURSTLEN,
    parameter logic [7:0] PAGE = mcDefs::PAGE_DEFAULT
) (
    input  logic            clk,
    input  logic            resetH,
    mem_burst_ctrl_if.slave bus
);
    import mcDefs::*;
    localparam int ADDRWIDTH = $clog2(MEMSIZE);
    mc_state_t             r_state, w_next;
    logic                  w_page_hit, w_accept, w_burst, w_last;
    logic [ADDRWIDTH-1:0]  w_addr;
    logic [BUSWIDTH-1:0]   r_rd_data;
    logic                  r_rd_valid;
    assign w_page_hit = bus.req_addr[ADDRWIDTH +: 8] == PAGE;
    assign w_accept   = r_state == IDLE && bus.req_valid && w_page_hit;
    // Gating with resetH makes a reset abort the burst on the very edge it is sampled
    assign w_burst    = (r_state == RD_BURST || r_state == WR_BURST) && !resetH;
    burst_addr_gen #(.ADDRWIDTH(ADDRWIDTH), .BURSTLEN(BURSTLEN)) u_addr_gen (
        .clk          (clk),
        .resetH       (resetH),
        .i_load       (w_accept),
        .i_step       (w_burst),
        .i_start_addr (bus.req_addr[ADDRWIDTH-1:0]),
        .o_addr       (w_addr),
        .o_last       (w_last)
    );
    always_ff @(posedge clk) begin
        if (resetH) r_state <= IDLE;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next       = r_state;
        bus.mem_rdEn = 1'b0;
        bus.mem_wrEn = 1'b0;
        case (r_state)
            IDLE:     w_next = w_accept ? (bus.req_rw ? RD_BURST : WR_BURST) : IDLE;
            RD_BURST: begin
                bus.mem_rdEn = !resetH;
                w_next       = w_last ? RD_DRAIN : RD_BURST;
            end
            WR_BURST: begin
                bus.mem_wrEn = !resetH;
                w_next       = w_last ? IDLE : WR_BURST;
            end
            default:  w_next = IDLE;
        endcase
        bus.req_ready = r_state == IDLE;
        bus.wr_ready  = bus.mem_wrEn;
        bus.mem_din   = bus.mem_wrEn ? bus.wr_data : {BUSWIDTH{1'b0}};
        bus.mem_addr  = w_burst ? w_addr : '0;
    end
    always_ff @(posedge clk) begin
        if (resetH) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= r_state == RD_BURST;
            if (r_state == RD_BURST) r_rd_data <= bus.mem_dout;
        end
    end
    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
`ifdef MEMCTRL_PAGE_ERR_EN
    logic       w_miss, r_req_err;
    logic [7:0] r_err_cnt;
    assign w_miss = r_state == IDLE && bus.req_valid && !w_page_hit;
    always_ff @(posedge clk) begin
        if (resetH) begin
            r_req_err <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_req_err <= w_miss;
            if (w_miss && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 1'b1;
        end
    end
    assign bus.req_err = r_req_err;
    assign bus.err_cnt = r_err_cnt;
`endif
endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb_mem_burst_ctrl: randomized scenario bench with a memory array and an arithmetic wrap-burst reference model.
module tb_mem_burst_ctrl;
    localparam int BL = 4;
    logic clk = 1'b0, resetH = 1'b1, mem_load = 1'b1;
    always #5 clk = ~clk;
    mem_burst_ctrl_if bus ();
    mem_burst_ctrl dut (.clk(clk), .resetH(resetH), .bus(bus));
    logic [7:0] mem [256];
    logic [7:0] exp_mem [256];
    int n_cmp = 0, n_fail = 0, act_cnt = 0, both_cnt = 0;
    function automatic logic [7:0] seed(int i);
        return 8'(i * 37 + 91);
    endfunction
    function automatic logic [7:0] beat_addr(logic [7:0] s, int i);
        return 8'((int'(s) / BL) * BL + (int'(s) % BL + i) % BL);
    endfunction
    always @(posedge clk) begin
        if (mem_load) for (int i = 0; i < 256; i++) mem[i] <= seed(i);
        else if (bus.mem_wrEn) mem[bus.mem_addr] <= bus.mem_din;
    end
    assign bus.mem_dout = bus.mem_rdEn ? mem[bus.mem_addr] : 8'h00;
    always @(negedge clk) begin
        if (bus.mem_rdEn || bus.mem_wrEn) act_cnt <= act_cnt + 1;
        if (bus.mem_rdEn && bus.mem_wrEn) both_cnt <= both_cnt + 1;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end
    task automatic do_write(input logic [15:0] a, input logic [BL-1:0][7:0] d, output logic [BL-1:0][7:0] addrs, output int nrdy);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_rw = 1'b0; bus.req_addr = a;
        nrdy = 0;
        for (int i = 0; i < BL; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            bus.wr_data = d[i];
            addrs[i] = bus.mem_addr;
            if (bus.wr_ready) nrdy++;
        end
        @(negedge clk);
        if (a[15:8] == 8'h02) for (int i = 0; i < BL; i++) exp_mem[beat_addr(a[7:0], i)] = d[i];
    endtask
    task automatic do_read(input logic [15:0] a, input logic [15:0] a2, input bit inject, output logic [BL-1:0][7:0] d, output int first, output int nbeats, output bit consec);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_rw = 1'b1; bus.req_addr = a;
        first = -1; nbeats = 0; consec = 1'b1; d = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            bus.req_valid = inject && (c == 2 || c == 3);
            bus.req_addr = a2;
            if (bus.rd_valid) begin
                if (first < 0) first = c;
                else if (c != first + nbeats) consec = 1'b0;
                if (nbeats < BL) d[nbeats] = bus.rd_data;
                nbeats++;
            end
        end
        bus.req_valid = 1'b0;
    endtask
    task automatic test_reset;
        logic [15:0] a;
        logic [BL-1:0][7:0] d;
        int bad;
        n_cmp++;
        if ({bus.req_ready, bus.wr_ready, bus.rd_valid, bus.mem_rdEn, bus.mem_wrEn, bus.rd_data, bus.mem_addr, bus.mem_din} !== {1'b1, 28'h0}) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b wrr=%b rv=%b re=%b we=%b rd=%h ma=%h md=%h, required rdy=1 rest 0",
                bus.req_ready, bus.wr_ready, bus.rd_valid, bus.mem_rdEn, bus.mem_wrEn, bus.rd_data, bus.mem_addr, bus.mem_din);
        end
        a = {8'h02, 8'($urandom)};
        d = 32'($urandom);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_rw = 1'b0; bus.req_addr = a;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            bus.wr_data = d[i];
            exp_mem[beat_addr(a[7:0], i)] = d[i];
        end
        @(negedge clk);
        resetH = 1'b1;
        bus.wr_data = d[2];
        repeat (2) @(negedge clk);
        resetH = 1'b0;
        n_cmp++;
        if ({bus.req_ready, bus.wr_ready, bus.rd_valid, bus.mem_rdEn, bus.mem_wrEn, bus.rd_data, bus.mem_addr, bus.mem_din} !== {1'b1, 28'h0}) begin
            n_fail++;
            $display("FAIL reset_mid_burst: got rdy=%b wrr=%b rv=%b re=%b we=%b, required rdy=1 rest 0",
                bus.req_ready, bus.wr_ready, bus.rd_valid, bus.mem_rdEn, bus.mem_wrEn);
        end
        bad = 0;
        for (int i = 0; i < BL; i++) if (mem[beat_addr(a[7:0], i)] !== exp_mem[beat_addr(a[7:0], i)]) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_partial_write: got %0d wrong block words at start %h, required 0", bad, a);
        end
    endtask
    task automatic test_write_read;
        logic [BL-1:0][7:0] d, addrs, rd, exp_addrs;
        int nrdy, first, nb;
        bit consec;
        d = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        exp_addrs = {8'h13, 8'h12, 8'h11, 8'h10};
        do_write(16'h0210, d, addrs, nrdy);
        n_cmp++;
        if (addrs !== exp_addrs || nrdy != BL) begin
            n_fail++;
            $display("FAIL wr_addrs: got addrs=%h ready=%0d, required addrs=%h ready=%0d", addrs, nrdy, exp_addrs, BL);
        end
        do_read(16'h0210, 16'h0210, 1'b0, rd, first, nb, consec);
        n_cmp++;
        if (rd !== d) begin
            n_fail++;
            $display("FAIL rd_data: got %h, required %h", rd, d);
        end
        n_cmp++;
        if (first != 2 || nb != BL || !consec) begin
            n_fail++;
            $display("FAIL rd_timing: got first=%0d beats=%0d consec=%b, required first=2 beats=%0d consec=1", first, nb, consec, BL);
        end
    endtask
    task automatic test_wrap;
        logic [BL-1:0][7:0] addrs, exp_addrs;
        logic [5:0][7:0] got, want;
        int nrdy;
        exp_addrs = {8'h06, 8'h05, 8'h04, 8'h07};
        do_write(16'h0207, {8'h44, 8'h33, 8'h22, 8'h11}, addrs, nrdy);
        n_cmp++;
        if (addrs !== exp_addrs) begin
            n_fail++;
            $display("FAIL wrap_addrs: got %h, required %h", addrs, exp_addrs);
        end
        got  = {mem[8'h08], mem[8'h03], mem[8'h06], mem[8'h05], mem[8'h04], mem[8'h07]};
        want = {exp_mem[8'h08], exp_mem[8'h03], 8'h44, 8'h33, 8'h22, 8'h11};
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL wrap_mem: got {08,03,06,05,04,07}=%h, required %h", got, want);
        end
    endtask
    task automatic test_random;
        logic [15:0] a;
        logic [BL-1:0][7:0] d, addrs, exp_v;
        int nrdy, first, nb, bad;
        bit consec;
        for (int k = 0; k < 8; k++) begin
            a = {8'h02, 8'($urandom)};
            if ($urandom_range(1, 0) == 0) begin
                d = 32'($urandom);
                for (int i = 0; i < BL; i++) exp_v[i] = beat_addr(a[7:0], i);
                do_write(a, d, addrs, nrdy);
                n_cmp++;
                if (addrs !== exp_v || nrdy != BL) begin
                    n_fail++;
                    $display("FAIL rand_wr[%0d]: got addrs=%h ready=%0d, required addrs=%h ready=%0d", k, addrs, nrdy, exp_v, BL);
                end
            end else begin
                for (int i = 0; i < BL; i++) exp_v[i] = exp_mem[beat_addr(a[7:0], i)];
                do_read(a, a, 1'b0, d, first, nb, consec);
                n_cmp++;
                if (d !== exp_v || first != 2 || nb != BL || !consec) begin
                    n_fail++;
                    $display("FAIL rand_rd[%0d]: got data=%h first=%0d beats=%0d, required data=%h first=2 beats=%0d", k, d, first, nb, exp_v, BL);
                end
            end
        end
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rand_mem: got %0d differing words, required 0", bad);
        end
    endtask
    task automatic test_page_filter;
        int a0, bad;
        a0 = act_cnt;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_rw = 1'($urandom); bus.req_addr = {8'h05, 8'($urandom)};
        @(negedge clk);
        bus.req_valid = 1'b0;
`ifdef MEMCTRL_PAGE_ERR_EN
        n_cmp++;
        if (bus.req_err !== 1'b1) begin
            n_fail++;
            $display("FAIL req_err_pulse: got %b, required 1", bus.req_err);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.req_err !== 1'b0 || bus.err_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL req_err_after: got err=%b cnt=%0d, required err=0 cnt=1", bus.req_err, bus.err_cnt);
        end
`endif
        repeat (4) @(negedge clk);
        n_cmp++;
        if (act_cnt != a0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL page_filter: got activity=%0d ready=%b, required activity=0 ready=1", act_cnt - a0, bus.req_ready);
        end
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL page_mem: got %0d differing words, required 0", bad);
        end
    endtask
    task automatic test_busy;
        logic [15:0] a;
        logic [BL-1:0][7:0] d, exp_v;
        int first, nb;
        bit consec;
        a = {8'h02, 8'($urandom)};
        for (int i = 0; i < BL; i++) exp_v[i] = exp_mem[beat_addr(a[7:0], i)];
        do_read(a, {8'h02, 8'($urandom)}, 1'b1, d, first, nb, consec);
        n_cmp++;
        if (d !== exp_v || first != 2 || nb != BL || !consec) begin
            n_fail++;
            $display("FAIL busy_burst: got data=%h first=%0d beats=%0d, required data=%h first=2 beats=%0d", d, first, nb, exp_v, BL);
        end
        n_cmp++;
        if (bus.req_ready !== 1'b1 || bus.mem_rdEn !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_ignored: got ready=%b rdEn=%b, required ready=1 rdEn=0", bus.req_ready, bus.mem_rdEn);
        end
    endtask
    task automatic test_back_to_back;
        logic [15:0] a, b;
        logic [BL-1:0][7:0] wd, rdd, exp_r;
        int rd_first, wr_first, rdy_c, nrd, k, bc0, bad;
        a = {8'h02, 8'($urandom)};
        b = {8'h02, 8'($urandom)};
        wd = 32'($urandom);
        for (int i = 0; i < BL; i++) exp_r[i] = exp_mem[beat_addr(a[7:0], i)];
        bc0 = both_cnt;
        rd_first = -1; wr_first = -1; rdy_c = -1; nrd = 0; k = 0; rdd = '0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_rw = 1'b1; bus.req_addr = a;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (bus.mem_rdEn && rd_first < 0) begin
                rd_first = c;
                bus.req_rw = 1'b0;
                bus.req_addr = b;
            end
            if (rd_first > 0 && rdy_c < 0 && bus.req_ready) rdy_c = c;
            if (bus.rd_valid && nrd < BL) begin
                rdd[nrd] = bus.rd_data;
                nrd++;
            end
            if (bus.mem_wrEn) begin
                if (wr_first < 0) wr_first = c;
                bus.req_valid = 1'b0;
                if (k < BL) bus.wr_data = wd[k];
                k++;
            end
        end
        bus.req_valid = 1'b0;
        for (int i = 0; i < BL; i++) exp_mem[beat_addr(b[7:0], i)] = wd[i];
        n_cmp++;
        if (rd_first != 1 || rdy_c != 6 || wr_first != 7 || k != BL) begin
            n_fail++;
            $display("FAIL b2b_timing: got rd=%0d ready=%0d wr=%0d beats=%0d, required rd=1 ready=6 wr=7 beats=%0d", rd_first, rdy_c, wr_first, k, BL);
        end
        n_cmp++;
        if (rdd !== exp_r) begin
            n_fail++;
            $display("FAIL b2b_rd_data: got %h, required %h", rdd, exp_r);
        end
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) bad++;
        n_cmp++;
        if (bad != 0 || both_cnt != bc0) begin
            n_fail++;
            $display("FAIL b2b_mem: got %0d differing words and %0d rd/wr overlaps, required 0 and 0", bad, both_cnt - bc0);
        end
    endtask
    initial begin
        bus.req_valid = 1'b0;
        bus.req_rw = 1'b0;
        bus.req_addr = '0;
        bus.wr_data = '0;
        for (int i = 0; i < 256; i++) exp_mem[i] = seed(i);
        repeat (3) @(negedge clk);
        resetH = 1'b0;
        mem_load = 1'b0;
        test_reset();
        test_write_read();
        test_wrap();
        test_page_filter();
        test_random();
        test_busy();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
